// File: rtl/xs_mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the memory port arbiter.
package xs_mem_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  typedef logic [2:0] req_id_t;

  typedef struct packed {
    logic                   any;
    req_id_t                id;
    logic [NUM_REQ_MAX-1:0] grant;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping at num_req back to 0.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ_MAX-1:0] valid,
                                       input req_id_t                ptr,
                                       input int                     num_req);
    rr_pick_t r;
    int       idx;
    req_id_t  cur;
    r = '0;
    for (int k = 0; k < NUM_REQ_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      cur = req_id_t'(idx);
      if ((k < num_req) && !r.any && valid[cur]) begin
        r.any        = 1'b1;
        r.id         = cur;
        r.grant[cur] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xs_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the current pointer; the
// pointer moves past the winner only when the caller reports a handshake.
module xs_rr_arbiter
  import xs_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            id,
  output logic               any
);

  localparam req_id_t LAST_ID = req_id_t'(NUM_REQ - 1);

  req_id_t                ptr_d, ptr_q;
  logic [NUM_REQ_MAX-1:0] valid_ext;
  rr_pick_t               pick;
  logic                   unused_pick_hi;

  // Pick the winner and compute the next pointer.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    pick                     = rr_pick(valid_ext, ptr_q, NUM_REQ);
    grant                    = pick.grant[NUM_REQ-1:0];
    id                       = pick.id;
    any                      = pick.any;
    unused_pick_hi           = ^pick.grant;
    ptr_d                    = ptr_q;
    if (advance) begin
      ptr_d = (pick.id == LAST_ID) ? '0 : req_id_t'(pick.id + 3'd1);
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xs_mem_port_arbiter.sv
// Shares one read and one write port of the 1R1W memory helper between
// NUM_REQ requesters. Reads are tagged with the winner ID and the data
// returned one cycle later is steered back with a one-hot strobe.
module xs_mem_port_arbiter
  import xs_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 64,
  parameter int DATA_W  = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       init_done,
  input  logic [NUM_REQ-1:0]         rd_req_valid,
  output logic [NUM_REQ-1:0]         rd_req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]   rd_req_index,
  output logic [NUM_REQ-1:0]         rd_rsp_valid,
  output logic [DATA_W-1:0]          rd_rsp_data,
  input  logic [NUM_REQ-1:0]         wr_req_valid,
  output logic [NUM_REQ-1:0]         wr_req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]   wr_req_index,
  input  logic [NUM_REQ*DATA_W-1:0]  wr_req_data,
  input  logic [NUM_REQ*DATA_W-1:0]  wr_req_mask,
  output logic                       mem_r_enable,
  output logic [IDX_W-1:0]           mem_r_index,
  input  logic [DATA_W-1:0]          mem_r_data,
  output logic                       mem_w_enable,
  output logic [IDX_W-1:0]           mem_w_index,
  output logic [DATA_W-1:0]          mem_w_data,
  output logic [DATA_W-1:0]          mem_w_mask
);

  logic [NUM_REQ-1:0] rd_grant, wr_grant;
  req_id_t            rd_id, wr_id;
  logic               rd_any, wr_any;
  logic               rd_fire, wr_fire, hazard;
  logic [IDX_W-1:0]   rd_idx_sel, wr_idx_sel;
  logic [DATA_W-1:0]  wr_data_sel, wr_mask_sel;
  logic               rsp_vld_d, rsp_vld_q;
  req_id_t            rsp_id_d, rsp_id_q;

  xs_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (rd_req_valid),
    .advance (rd_fire),
    .grant   (rd_grant),
    .id      (rd_id),
    .any     (rd_any)
  );

  xs_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (wr_req_valid),
    .advance (wr_fire),
    .grant   (wr_grant),
    .id      (wr_id),
    .any     (wr_any)
  );

  // Winner payload muxes, RAW hazard and grant/issue decisions.
  always_comb begin
    rd_idx_sel  = '0;
    wr_idx_sel  = '0;
    wr_data_sel = '0;
    wr_mask_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_id == req_id_t'(i)) rd_idx_sel = rd_req_index[i*IDX_W +: IDX_W];
      if (wr_id == req_id_t'(i)) begin
        wr_idx_sel  = wr_req_index[i*IDX_W +: IDX_W];
        wr_data_sel = wr_req_data[i*DATA_W +: DATA_W];
        wr_mask_sel = wr_req_mask[i*DATA_W +: DATA_W];
      end
    end
    // A same-index write wins so the deferred read observes the new data.
    hazard       = rd_any && wr_any && (rd_idx_sel == wr_idx_sel);
    wr_fire      = init_done && wr_any;
    rd_fire      = init_done && rd_any && !hazard;
    rd_req_ready = rd_fire ? rd_grant : '0;
    wr_req_ready = wr_fire ? wr_grant : '0;
    mem_r_enable = rd_fire;
    mem_r_index  = rd_fire ? rd_idx_sel : '0;
    mem_w_enable = wr_fire;
    mem_w_index  = wr_fire ? wr_idx_sel : '0;
    mem_w_data   = wr_fire ? wr_data_sel : '0;
    mem_w_mask   = wr_fire ? wr_mask_sel : '0;
    rsp_vld_d    = rd_fire;
    rsp_id_d     = rd_fire ? rd_id : rsp_id_q;
  end

  // Steer the helper's read data back to the tagged requester.
  always_comb begin
    rd_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_rsp_valid[i] = rsp_vld_q && (rsp_id_q == req_id_t'(i));
    end
    rd_rsp_data = rsp_vld_q ? mem_r_data : '0;
  end

  // In-flight read tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

endmodule
